// File: rtl/fetch_skid_buffer_pkg.sv
// Shared fetch/decode pipeline types: the fetch packet and the skid buffer state encoding.
package fetch_skid_buffer_pkg;

    localparam int FETCH_XLEN = 32;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] instruction;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_packet_t;

    // Encoding 2'd3 is unused; the state machine steers it back to EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    function automatic logic [1:0] state_occupancy(input skid_state_t state);
        case (state)
            BUSY:    return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_skid_buffer_reg.sv
// Load-enabled packet register with asynchronous clear; holds its value unless en_i is high.
module pipe_reg_en
    import fetch_skid_buffer_pkg::*;
#(
    parameter type T = fetch_packet_t
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  T     d_i,
    output T     q_o
);

    T data_q;
    T data_d;

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/fetch_skid_buffer.sv
// Two-entry skid buffer between fetch and decode; ready_o is a pure decode of the state flop
// so the stall path back to PC generation never passes through ready_i.
module fetch_skid_buffer
    import fetch_skid_buffer_pkg::*;
#(
    parameter int XLEN = FETCH_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] instruction_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] instruction_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            ready_i,
    output logic [1:0]      occupancy_o
);

    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc;
    } packet_t;

    skid_state_t state_q;
    skid_state_t state_d;
    packet_t     in_pkt;
    packet_t     main_pkt;
    packet_t     skid_pkt;
    packet_t     main_load_pkt;
    logic        main_en;
    logic        skid_en;
    logic        main_from_skid;

    assign in_pkt        = '{instruction: instruction_i, pc: pc_i};
    assign main_load_pkt = main_from_skid ? skid_pkt : in_pkt;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (valid_i) begin
                        main_en = 1'b1;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (valid_i && ready_i) begin
                        main_en = 1'b1;
                    end else if (valid_i) begin
                        skid_en = 1'b1;
                        state_d = FULL;
                    end else if (ready_i) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // Inputs are not sampled here: ready_o is low, so fetch is holding.
                    if (ready_i) begin
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_reg_en #(.T(packet_t)) u_main_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (main_en),
        .d_i   (main_load_pkt),
        .q_o   (main_pkt)
    );

    pipe_reg_en #(.T(packet_t)) u_skid_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (skid_en),
        .d_i   (in_pkt),
        .q_o   (skid_pkt)
    );

    assign valid_o       = (state_q != EMPTY);
    assign ready_o       = (state_q != FULL);
    assign occupancy_o   = state_occupancy(state_q);
    assign instruction_o = main_pkt.instruction;
    assign pc_o          = main_pkt.pc;

endmodule
